allocator_3_rr: RTL
===================

// Module: allocator_3_rr
// PURPOSE
//  Output-port allocator for one switch output. Shares the output between 3 input ports.
//  Arbitrates head-flit requests round-robin and drives the one-hot mux_sel of the 3:1 crossbar multiplexer.
//  Locks the grant for a whole packet (wormhole), from head flit to tail flit.
//  One instance per switch output port, between the input buffers and the crossbar mux.
// PARAMETERS
//  N_INPUTS  3  number of competing input ports; mux_sel/grant width
//  PTR_W     2  width of round-robin pointer (ceil(log2(N_INPUTS)))
// PORTS
//  clock       in   1         single clock, rising edge
//  reset       in   1         asynchronous, active-high
//  req         in   N_INPUTS  req[i]=1: input i shows a valid head flit routed to this output
//  flit_valid  in   N_INPUTS  input i presents a valid flit (head/body/tail)
//  flit_tail   in   N_INPUTS  flit presented by input i is a tail (may coincide with head)
//  out_stall   in   1         downstream cannot accept a flit this cycle
//  mux_sel     out  N_INPUTS  one-hot select to crossbar mux (1,2,4 = input 0,1,2); 0 = no source
//  flit_ack    out  N_INPUTS  flit of input i transferred this cycle; pop its buffer
//  out_valid   out  1         output flit valid this cycle
//  busy        out  1         output locked to a packet
// BEHAVIOUR
//  Reset (async, asserted): state=IDLE, mux_sel=0, ptr=0, busy=0, out_valid=0, flit_ack=0.
//   Any packet in flight is dropped; upstream handles recovery.
//  FSM states: IDLE, LOCKED. mux_sel, ptr and state are registers. flit_ack and out_valid are combinational.
//  IDLE:
//   - mux_sel=0, out_valid=0, flit_ack=0.
//   - If req!=0 at a clock edge: pick the first set req[i] searching from ptr upward, mod N_INPUTS.
//   - Register mux_sel=onehot(i), go to LOCKED. Arbitration latency is 1 cycle.
//  LOCKED, granted input g:
//   - out_valid = flit_valid[g].
//   - flit_ack[g] = flit_valid[g] & ~out_stall; all other flit_ack bits = 0.
//   - Transfer with flit_tail[g]=1: next state IDLE, mux_sel=0, ptr=(g+1) mod N_INPUTS.
//   - Consequence: one bubble cycle between packets on the same output.
//   - Tail presented while out_stall=1: no transfer, no release; lock holds until accepted.
//   - req changes from other or same inputs are ignored while LOCKED; no preemption.
//   - flit_valid[g]=0 (upstream gap): hold lock, out_valid=0.
//  Single-flit packet (head=tail): LOCKED for exactly the cycles until its transfer, then IDLE.
//  ptr advances only on packet release, never on grant. This guarantees starvation freedom:
//   each requester waits at most N_INPUTS-1 packets.
//  ptr wrap: 2 -> 0. ptr values >= N_INPUTS are unreachable; treat as 0.
//  Invariant: mux_sel is 0 or exactly one-hot. busy = (state==LOCKED) = |mux_sel.
// STRUCTURE
//  Package noc_alloc_pkg:
//   - state enum (IDLE=1'b0, LOCKED=1'b1)
//   - N_INPUTS default
//   - function onehot(idx)
//   - function ptr_inc(ptr) with wrap
//  Sub-module rr_pick_3: combinational rotate-priority picker.
//   - Inputs: req[N], ptr[PTR_W]. Outputs: gnt_onehot[N], gnt_idx[PTR_W], any.
//  Top level: FSM, mux_sel/ptr registers, ack/valid logic.
// TESTING
//  1 Reset: assert reset mid-packet (LOCKED on input 1) -> mux_sel=0, busy=0, ptr=0 immediately.
//    Still 0 on the first edge after deassert.
//  2 Single req: req=3'b010, 3-flit packet, out_stall=0 -> cycle+1 mux_sel=3'b010.
//    flit_ack[1] 3 cycles; IDLE after tail; ptr=2.
//  3 Round robin: req=3'b111 held, 1-flit packets -> grant order 0,1,2,0.
//    mux_sel pattern 001,000,010,000,100,000,001.
//  4 Stall on tail: lock input 2, tail with out_stall=1 for 4 cycles -> mux_sel stays 3'b100.
//    flit_ack=0 until stall drops; release on the next cycle.
//  5 No preemption: lock input 0, assert req[1],req[2] mid-packet -> mux_sel stays 3'b001 until tail.
//    Then input 1 is granted.
//  6 Upstream gap: flit_valid[g]=0 for 2 cycles mid-packet -> out_valid=0, lock held, no flit_ack.

Source files
------------

// File: rtl/noc_alloc_pkg.sv
// Shared definitions for the output-port allocator.
//   - N_INPUTS / PTR_W : number of competing input ports and pointer width
//   - state_t          : allocator FSM state (IDLE / LOCKED)
//   - onehot()         : index -> one-hot select vector
//   - ptr_inc()        : round-robin pointer increment with wrap (2 -> 0)
package noc_alloc_pkg;

  localparam int N_INPUTS = 3;
  localparam int PTR_W    = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  function automatic logic [N_INPUTS-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [N_INPUTS-1:0] v;
    v = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (idx == PTR_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Out-of-range pointer values are unreachable; folding them to 0 keeps
  // the arbiter well defined even if one ever appeared.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p >= PTR_W'(N_INPUTS - 1)) return '0;
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/allocator_3_rr_if.sv
// Handshake bundle between the input buffers / crossbar and one output
// allocator.
//   req        : input i has a valid head flit routed to this output
//   flit_valid : input i presents a valid flit (head/body/tail)
//   flit_tail  : the flit presented by input i is a tail
//   out_stall  : downstream cannot accept a flit this cycle
//   mux_sel    : one-hot crossbar select, 0 = no source
//   flit_ack   : flit of input i transferred this cycle (pop its buffer)
//   out_valid  : output flit valid this cycle
//   busy       : output locked to a packet
// Transfer rule: a flit of the granted input moves exactly in a cycle where
// mux_sel selects it, its flit_valid is 1 and out_stall is 0; flit_ack marks
// that cycle. Nothing moves otherwise, and upstream keeps presenting the flit.
interface allocator_3_rr_if;
  import noc_alloc_pkg::*;

  logic [N_INPUTS-1:0] req;
  logic [N_INPUTS-1:0] flit_valid;
  logic [N_INPUTS-1:0] flit_tail;
  logic                out_stall;
  logic [N_INPUTS-1:0] mux_sel;
  logic [N_INPUTS-1:0] flit_ack;
  logic                out_valid;
  logic                busy;

  // Allocator side.
  modport slave (
    input  req, flit_valid, flit_tail, out_stall,
    output mux_sel, flit_ack, out_valid, busy
  );

  // Input-buffer / environment side.
  modport master (
    output req, flit_valid, flit_tail, out_stall,
    input  mux_sel, flit_ack, out_valid, busy
  );

endinterface

// File: rtl/rr_pick_3.sv
// Combinational rotate-priority picker.
//   i_req        : request vector
//   i_ptr        : highest-priority index (values >= N_INPUTS treated as 0)
//   o_gnt_onehot : one-hot winner, 0 when no request
//   o_gnt_idx    : winner index
//   o_any        : at least one request present
// The winner is the first set request found scanning upward from i_ptr,
// wrapping modulo N_INPUTS.
module rr_pick_3
  import noc_alloc_pkg::*;
(
  input  logic [N_INPUTS-1:0] i_req,
  input  logic [PTR_W-1:0]    i_ptr,
  output logic [N_INPUTS-1:0] o_gnt_onehot,
  output logic [PTR_W-1:0]    o_gnt_idx,
  output logic                o_any
);

  logic [PTR_W-1:0] w_base;
  logic [PTR_W:0]   w_cand;

  assign w_base = (i_ptr >= PTR_W'(N_INPUTS)) ? '0 : i_ptr;

  always_comb begin
    o_gnt_onehot = '0;
    o_gnt_idx    = '0;
    o_any        = 1'b0;
    w_cand       = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      // One extra bit so base+k cannot overflow before the modulo fold.
      w_cand = {1'b0, w_base} + (PTR_W+1)'(k);
      if (w_cand >= (PTR_W+1)'(N_INPUTS)) w_cand = w_cand - (PTR_W+1)'(N_INPUTS);
      if (!o_any && i_req[w_cand[PTR_W-1:0]]) begin
        o_any        = 1'b1;
        o_gnt_idx    = w_cand[PTR_W-1:0];
        o_gnt_onehot = onehot(w_cand[PTR_W-1:0]);
      end
    end
  end

endmodule

// File: rtl/allocator_3_rr.sv
// Wormhole output-port allocator for one switch output shared by 3 inputs.
//   i_clk       : clock, rising edge
//   i_rst       : asynchronous active-high reset
//   bus         : allocator_3_rr_if.slave handshake bundle
//   o_dbg_state : current FSM state
//   o_dbg_ptr   : current round-robin pointer
// In IDLE a round-robin pick among head-flit requests is registered into
// mux_sel (1-cycle arbitration latency). In LOCKED the granted input owns
// the output until its tail flit is actually transferred; only then is the
// lock dropped and the pointer moved past the releasing input. Requests are
// ignored while locked, so a packet is never preempted.
module allocator_3_rr
  import noc_alloc_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  allocator_3_rr_if.slave       bus,
  output state_t                o_dbg_state,
  output logic [PTR_W-1:0]      o_dbg_ptr
);

  state_t              r_state,   w_state_nxt;
  logic [N_INPUTS-1:0] r_mux_sel, w_mux_sel_nxt;
  logic [PTR_W-1:0]    r_ptr,     w_ptr_nxt;
  logic [PTR_W-1:0]    r_gnt_idx, w_gnt_idx_nxt;

  logic [N_INPUTS-1:0] w_pick_onehot;
  logic [PTR_W-1:0]    w_pick_idx;
  logic                w_pick_any;

  logic                w_locked;
  logic                w_sel_valid;
  logic                w_sel_tail;
  logic                w_xfer;
  logic                w_release;

  rr_pick_3 u_pick (
    .i_req        (bus.req),
    .i_ptr        (r_ptr),
    .o_gnt_onehot (w_pick_onehot),
    .o_gnt_idx    (w_pick_idx),
    .o_any        (w_pick_any)
  );

  // mux_sel is zero outside LOCKED, so masking with it selects the granted
  // input's flit_valid / flit_tail.
  assign w_locked    = (r_state == ST_LOCKED);
  assign w_sel_valid = |(bus.flit_valid & r_mux_sel);
  assign w_sel_tail  = |(bus.flit_tail  & r_mux_sel);
  assign w_xfer      = w_locked & w_sel_valid & ~bus.out_stall;
  assign w_release   = w_xfer & w_sel_tail;

  always_comb begin
    w_state_nxt   = r_state;
    w_mux_sel_nxt = r_mux_sel;
    w_ptr_nxt     = r_ptr;
    w_gnt_idx_nxt = r_gnt_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt   = ST_LOCKED;
          w_mux_sel_nxt = w_pick_onehot;
          w_gnt_idx_nxt = w_pick_idx;
        end
      end
      ST_LOCKED: begin
        if (w_release) begin
          w_state_nxt   = ST_IDLE;
          w_mux_sel_nxt = '0;
          w_ptr_nxt     = ptr_inc(r_gnt_idx);
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_mux_sel_nxt = '0;
        w_ptr_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_mux_sel <= '0;
      r_ptr     <= '0;
      r_gnt_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mux_sel <= w_mux_sel_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
    end
  end

  assign bus.mux_sel   = r_mux_sel;
  assign bus.out_valid = w_locked & w_sel_valid;
  assign bus.flit_ack  = (w_locked && !bus.out_stall) ? (bus.flit_valid & r_mux_sel) : '0;
  assign bus.busy      = w_locked;

  assign o_dbg_state = r_state;
  assign o_dbg_ptr   = r_ptr;

endmodule
